// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants, instruction format enum and the writer FSM state type.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_FULL   = 1'b1
  } state_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:                                  f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:   f = FMT_I;
      OP_STORE:                              f = FMT_S;
      OP_BRANCH:                             f = FMT_B;
      OP_LUI, OP_AUIPC:                      f = FMT_U;
      OP_JAL:                                f = FMT_J;
      default:                               f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv32_field_packer.sv
// Combinational RV32I field packer: fields plus immediate in, 32-bit instruction word and illegal flag out.
`timescale 1ns/1ps
module rv32_field_packer
  import rv32_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  fmt_e fmt;
  logic is_shift;

  assign fmt      = fmt_of(opcode);
  assign is_shift = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        // Shift immediates carry funct7 in the upper bits and the shamt in imm[4:0].
        if (is_shift) word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else          word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_writer.sv
// Accepts instruction field sets over valid/ready, encodes them and writes the words
// sequentially into instruction memory one cycle later via an auto-incrementing pointer.
`timescale 1ns/1ps
module instr_encoder_writer
  import rv32_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              flush,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal,
  output logic              state_dbg
);

  // Handshake: a field set transfers on a rising edge where in_valid && in_ready.
  // in_valid may be held; the source must keep fields stable until the transfer.

  localparam int unsigned     DEPTH_I = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];
  localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [31:0] pk_word;
  logic        pk_illegal;
  logic        accept;

  rv32_field_packer u_packer (
    .opcode  (opcode),
    .rd      (rd),
    .funct3  (funct3),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct7  (funct7),
    .imm     (imm),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  assign in_ready = (state_q == ST_ACCEPT) && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q | (accept & pk_illegal);
    // Flush beats a coincident transfer: the accepted word is dropped.
    if (flush) begin
      state_d = ST_ACCEPT;
      ptr_d   = BASE;
      count_d = '0;
    end else if (accept && !pk_illegal) begin
      we_d    = 1'b1;
      addr_d  = ptr_q;
      wdata_d = pk_word;
      ptr_d   = ptr_q + 1'b1;
      count_d = count_q + 1'b1;
      if (count_d == DEPTH) state_d = ST_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCEPT;
      ptr_q   <= BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign count       = count_q;
  assign full        = (state_q == ST_FULL);
  assign err_illegal = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Directed bench for instr_encoder_writer with a 4-word memory (ADDR_W=2).
`timescale 1ns/1ps
module tb_instr_encoder_writer;

  localparam int unsigned ADDR_W = 2;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              flush;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err_illegal;
  logic              state_dbg;

  int n_asserts = 0;
  int n_fail    = 0;

  instr_encoder_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .rd          (rd),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct7      (funct7),
    .imm         (imm),
    .flush       (flush),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .count       (count),
    .full        (full),
    .err_illegal (err_illegal),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                            input logic [31:0] im);
    opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
  endtask

  task automatic offer(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                       input logic [31:0] im);
    set_fields(op, d, f3, s1, s2, f7, im);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] w,
                             input logic [ADDR_W:0] c);
    check({tag, "_we"},    32'(mem_we),    32'd1);
    check({tag, "_addr"},  32'(mem_addr),  32'(a));
    check({tag, "_wdata"}, mem_wdata,      w);
    check({tag, "_count"}, 32'(count),     32'(c));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    set_fields(7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we",       32'(mem_we),   32'd0);
    check("rst_addr",     32'(mem_addr), 32'd0);
    check("rst_wdata",    mem_wdata,     32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_full",     32'(full),     32'd0);
    check("rst_err",      32'(err_illegal), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // add x3, x1, x2
    offer(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    check_write("r_add", 2'd0, 32'h002081B3, 3'd1);
    tick();
    check("r_add_we_drop", 32'(mem_we), 32'd0);
    do_flush();
    check("flush1_count", 32'(count), 32'd0);

    // Back-to-back addi then sw with in_valid held high
    set_fields(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd10);
    in_valid = 1'b1;
    tick();
    check_write("addi", 2'd0, 32'h00A00293, 3'd1);
    set_fields(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    check_write("sw", 2'd1, 32'h0020A423, 3'd2);
    tick();
    check("b2b_idle_we", 32'(mem_we), 32'd0);
    do_flush();

    // Immediate scrambles
    offer(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8);
    check_write("beq", 2'd0, 32'h00208463, 3'd1);
    offer(7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
    check_write("lui", 2'd1, 32'h123450B7, 3'd2);
    offer(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd16);
    check_write("jal", 2'd2, 32'h010000EF, 3'd3);

    // Illegal opcode: handshake completes, no write, sticky error
    offer(7'h7F, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'd0);
    check("illegal_we",    32'(mem_we),      32'd0);
    check("illegal_err",   32'(err_illegal), 32'd1);
    check("illegal_count", 32'(count),       32'd3);

    // Fourth legal word lands at addr 3 and fills the memory
    offer(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd10);
    check_write("fill", 2'd3, 32'h00A00293, 3'd4);
    check("fill_full",  32'(full),      32'd1);
    check("fill_ready", 32'(in_ready),  32'd0);
    check("fill_state", 32'(state_dbg), 32'd1);

    // Fifth offer is ignored while full
    offer(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    check("full_ignore_we",    32'(mem_we), 32'd0);
    check("full_ignore_count", 32'(count),  32'd4);

    do_flush();
    check("flush2_count", 32'(count),       32'd0);
    check("flush2_full",  32'(full),        32'd0);
    check("flush2_ready", 32'(in_ready),    32'd1);
    check("flush2_err",   32'(err_illegal), 32'd1);

    offer(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    check_write("after_flush", 2'd0, 32'h002081B3, 3'd1);

    // Flush coincident with a transfer: the write in progress completes, the new word is dropped
    set_fields(7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("coinc_we",    32'(mem_we), 32'd0);
    check("coinc_count", 32'(count),  32'd0);
    tick();
    check("coinc_we2",   32'(mem_we), 32'd0);

    // srai x1, x2, 3 with junk in unused immediate bits; addi first lands at addr 0
    offer(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd10);
    check_write("addi2", 2'd0, 32'h00A00293, 3'd1);
    offer(7'h13, 5'd1, 3'd5, 5'd2, 5'd0, 7'h20, 32'hFFFFFFE3);
    check_write("srai", 2'd1, 32'h40315093, 3'd2);

    // Reset while that write is in its mem_we cycle, with a new offer pending
    set_fields(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    in_valid = 1'b1;
    reset    = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    check("mid_rst_we",    32'(mem_we),      32'd0);
    check("mid_rst_addr",  32'(mem_addr),    32'd0);
    check("mid_rst_wdata", mem_wdata,        32'd0);
    check("mid_rst_count", 32'(count),       32'd0);
    check("mid_rst_full",  32'(full),        32'd0);
    check("mid_rst_err",   32'(err_illegal), 32'd0);
    reset = 1'b0;
    tick();
    check("post_mid_rst_we", 32'(mem_we), 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
